// File: rtl/instr_exec_reader.sv
// Instruction-register sweep reader: walks a range of instruction locations,
// executes each opcode on its operands and hands results out over a
// valid/ready port, one location at a time.

package instr_exec_reader_pkg;

  typedef enum logic [3:0] {
    OPC_ZERO  = 4'd0,
    OPC_PASSA = 4'd1,
    OPC_PASSB = 4'd2,
    OPC_ADD   = 4'd3,
    OPC_SUB   = 4'd4,
    OPC_MULT  = 4'd5,
    OPC_DIV   = 4'd6,
    OPC_MOD   = 4'd7,
    OPC_POW   = 4'd8
  } opcode_t;

  typedef struct packed {
    logic        [3:0]  opc;
    logic signed [31:0] op_a;
    logic signed [31:0] op_b;
    logic        [63:0] res;
  } instruction_t;

endpackage

module instr_exec_reader
  import instr_exec_reader_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [4:0]         start_ptr,
  input  logic [5:0]         count,
  input  logic               dir,
  output logic [4:0]         read_pointer,
  input  instruction_t       instruction_word,
  output logic               res_valid,
  input  logic               res_ready,
  output logic signed [63:0] res_data,
  output logic [4:0]         res_addr,
  output logic               res_err,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_OUT,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [4:0]         r_ptr;
  logic [5:0]         r_remain;
  logic               r_dir;
  logic [3:0]         r_opc;
  logic signed [63:0] r_a;
  logic signed [63:0] r_b;
  logic signed [63:0] r_acc;
  logic [4:0]         r_iter;
  logic signed [63:0] r_res_data;
  logic [4:0]         r_res_addr;
  logic               r_res_err;

  logic               w_exec_done;
  logic signed [63:0] w_exec_data;
  logic               w_exec_err;
  logic [4:0]         w_ptr_next;
  logic               w_unused_res;

  assign w_unused_res = ^instruction_word.res;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = (count != '0) ? S_FETCH : S_DONE;
      S_FETCH: w_next = S_EXEC;
      S_EXEC:  if (w_exec_done) w_next = S_OUT;
      S_OUT:   if (res_ready) w_next = (r_remain == 6'd1) ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Execute unit; POW reuses r_acc as running product, finishing on the op_b-th multiply
  always_comb begin
    w_exec_done = 1'b1;
    w_exec_data = '0;
    w_exec_err  = 1'b0;
    unique case (r_opc)
      OPC_ZERO:  w_exec_data = '0;
      OPC_PASSA: w_exec_data = r_a;
      OPC_PASSB: w_exec_data = r_b;
      OPC_ADD:   w_exec_data = r_a + r_b;
      OPC_SUB:   w_exec_data = r_a - r_b;
      OPC_MULT:  w_exec_data = r_a * r_b;
      OPC_DIV:   if (r_b != '0) w_exec_data = r_a / r_b;
      OPC_MOD:   if (r_b != '0) w_exec_data = r_a % r_b;
      OPC_POW: begin
        if (r_b < 0 || r_b > 31) begin
          w_exec_err = 1'b1;
        end else if (r_a == '0) begin
          w_exec_data = '0;
        end else if (r_b == '0) begin
          w_exec_data = 64'sd1;
        end else begin
          w_exec_data = r_acc * r_a;
          w_exec_done = (r_iter == (r_b[4:0] - 5'd1));
        end
      end
      default:   w_exec_err = 1'b1;
    endcase
  end

  // Pointer step with wrap in either direction
  always_comb begin
    w_ptr_next = r_ptr + 5'd1;
    if (r_dir) w_ptr_next = (r_ptr == '0) ? 5'(DEPTH - 1) : r_ptr - 5'd1;
    else if (r_ptr == 5'(DEPTH - 1)) w_ptr_next = '0;
  end

  // Datapath registers: sweep bookkeeping, operand capture, result hold
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr      <= '0;
      r_remain   <= '0;
      r_dir      <= 1'b0;
      r_opc      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_iter     <= '0;
      r_res_data <= '0;
      r_res_addr <= '0;
      r_res_err  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start && count != '0) begin
            r_ptr    <= start_ptr;
            r_remain <= count;
            r_dir    <= dir;
          end
        end
        S_FETCH: begin
          r_opc      <= instruction_word.opc;
          r_a        <= {{32{instruction_word.op_a[31]}}, instruction_word.op_a};
          r_b        <= {{32{instruction_word.op_b[31]}}, instruction_word.op_b};
          r_acc      <= 64'sd1;
          r_iter     <= '0;
          r_res_addr <= r_ptr;
        end
        S_EXEC: begin
          if (w_exec_done) begin
            r_res_data <= w_exec_data;
            r_res_err  <= w_exec_err;
          end else begin
            r_acc  <= w_exec_data;
            r_iter <= r_iter + 5'd1;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            r_remain <= r_remain - 6'd1;
            r_ptr    <= w_ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign read_pointer = r_ptr;
  assign res_valid    = (r_state == S_OUT);
  assign res_data     = r_res_data;
  assign res_addr     = r_res_addr;
  assign res_err      = r_res_err;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);

endmodule

// File: tb/tb_instr_exec_reader.sv
// Scoreboard bench for instr_exec_reader: expected results are queued when a
// sweep is issued and popped by a monitor whenever a result is transferred.

module tb_instr_exec_reader;
  import instr_exec_reader_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [4:0]         start_ptr;
  logic [5:0]         count;
  logic               dir;
  logic [4:0]         read_pointer;
  instruction_t       instruction_word;
  logic               res_valid;
  logic               res_ready;
  logic signed [63:0] res_data;
  logic [4:0]         res_addr;
  logic               res_err;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  instr_exec_reader #(.DEPTH(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .start_ptr        (start_ptr),
    .count            (count),
    .dir              (dir),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .res_addr         (res_addr),
    .res_err          (res_err),
    .busy             (busy),
    .done             (done)
  );

  instruction_t mem [32];
  assign instruction_word = mem[read_pointer];

  typedef struct {
    int     addr;
    longint data;
    int     err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  int   done_exp = 0;
  bit   rdy_rand = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instruction_t mk(input int opc, input int a, input int b);
    instruction_t w;
    w.opc  = 4'(opc);
    w.op_a = a;
    w.op_b = b;
    w.res  = {$urandom, $urandom};
    return w;
  endfunction

  // Reference semantics from the opcode rules, plain integer arithmetic
  function automatic void ref_exec(input instruction_t w, output longint r, output int e);
    longint a, b;
    a = w.op_a;
    b = w.op_b;
    r = 0;
    e = 0;
    case (int'(w.opc))
      0: r = 0;
      1: r = a;
      2: r = b;
      3: r = a + b;
      4: r = a - b;
      5: r = a * b;
      6: r = (b == 0) ? 0 : a / b;
      7: r = (b == 0) ? 0 : a % b;
      8: begin
        if (b < 0 || b > 31) e = 1;
        else if (a == 0) r = 0;
        else begin
          r = 1;
          for (int i = 0; i < b; i++) r = r * a;
        end
      end
      default: e = 1;
    endcase
  endfunction

  task automatic push_exp(input int addr, input longint data, input int err);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.err  = err;
    q.push_back(e);
  endtask

  task automatic push_model(input int sp, input int cnt, input int d);
    longint r;
    int     e, a;
    for (int i = 0; i < cnt; i++) begin
      a = d ? ((sp - i) % 32 + 32) % 32 : (sp + i) % 32;
      ref_exec(mem[a], r, e);
      push_exp(a, r, e);
    end
  endtask

  // Monitor: every visible result must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (done) begin
          done_seen++;
          check("done_with_pending", q.size(), 0);
        end
        if (res_valid) begin
          if (q.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            check("res_data", res_data, q[0].data);
            check("res_addr", res_addr, q[0].addr);
            check("res_err", res_err, q[0].err);
            if (res_ready) void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) res_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic pulse_start(input int sp, input int cnt, input int d);
    @(posedge clk);
    #1;
    start     = 1'b1;
    start_ptr = 5'(sp);
    count     = 6'(cnt);
    dir       = 1'(d);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc, output bit ok);
    cyc = 0;
    ok  = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1;
        break;
      end
      cyc++;
    end
  endtask

  task automatic run_start(input int sp, input int cnt, input int d,
                           input int exp_lat, input int stall, input bit noise);
    int cyc;
    bit ok;
    done_exp++;
    pulse_start(sp, cnt, d);
    if (exp_lat >= 0 || stall > 0) begin
      wait_valid(cyc, ok);
      check("valid_timeout", ok, 1);
      if (exp_lat >= 0) check("latency", cyc, exp_lat);
      if (stall > 0) begin
        repeat (stall) @(negedge clk);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
      end
    end
    ok = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
      if (noise) begin
        start     = ($urandom_range(0, 4) == 0);
        start_ptr = 5'($urandom);
        count     = 6'($urandom);
        dir       = 1'($urandom);
      end
    end
    start = 1'b0;
    #1;
    check("sweep_timeout", ok, 1);
    check("done_count", done_seen, done_exp);
    check("queue_empty", q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read_pointer"}, read_pointer, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_addr"}, res_addr, 0);
    check({tag, "_res_err"}, res_err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic abort_with_reset(input string tag);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs(tag);
    q.delete();
    #1;
    reset_n = 1'b1;
    check({tag, "_no_done"}, done_seen, done_exp);
  endtask

  task automatic load_basic();
    mem[0] = mk(3, 5, 3);
    mem[1] = mk(4, -7, 4);
    mem[2] = mk(5, -3, 6);
    mem[3] = mk(6, 9, 0);
  endtask

  initial begin
    int  cyc;
    bit  ok;
    int  sp, cnt, d;
    for (int i = 0; i < 32; i++) mem[i] = mk(0, 0, 0);
    reset_n   = 1'b0;
    start     = 1'b0;
    start_ptr = '0;
    count     = '0;
    dir       = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Basic four-op sweep with constant expectations
    load_basic();
    push_exp(0, 8, 0);
    push_exp(1, -11, 0);
    push_exp(2, -18, 0);
    push_exp(3, 0, 0);
    run_start(0, 4, 0, 2, 0, 0);

    // Decrementing sweep wrapping through 0 to 31
    mem[31] = mk(1, 77, 0);
    push_exp(1, -11, 0);
    push_exp(0, 8, 0);
    push_exp(31, 77, 0);
    run_start(1, 3, 1, -1, 0, 0);

    // POW cases and their latencies
    mem[5] = mk(8, 2, 10);
    push_exp(5, 1024, 0);
    run_start(5, 1, 0, 11, 0, 0);
    mem[6] = mk(8, 0, 0);
    push_exp(6, 0, 0);
    run_start(6, 1, 0, 2, 0, 0);
    mem[7] = mk(8, 3, -1);
    push_exp(7, 0, 1);
    run_start(7, 1, 0, 2, 0, 0);

    // Back-pressure: result must hold while res_ready is low
    mem[8] = mk(3, 100, -1);
    mem[9] = mk(2, 0, -5);
    push_exp(8, 99, 0);
    push_exp(9, -5, 0);
    res_ready = 1'b0;
    run_start(8, 2, 0, 2, 6, 0);

    // Illegal opcode, MOD sign, start ignored while busy
    mem[10] = mk(12, 4, 4);
    mem[11] = mk(7, -7, 2);
    push_exp(10, 0, 1);
    push_exp(11, -1, 0);
    run_start(10, 2, 0, -1, 0, 1);

    // Zero-count start goes straight to the done pulse
    run_start(20, 0, 0, -1, 0, 0);

    // Reset mid-POW
    mem[12] = mk(8, 3, 20);
    push_model(12, 1, 0);
    pulse_start(12, 1, 0);
    repeat (5) @(negedge clk);
    check("pow_busy", busy, 1);
    abort_with_reset("rst_pow");

    // Reset while a result waits in OUT
    mem[13] = mk(3, 1, 1);
    push_model(13, 1, 0);
    res_ready = 1'b0;
    pulse_start(13, 1, 0);
    wait_valid(cyc, ok);
    check("out_valid_timeout", ok, 1);
    abort_with_reset("rst_out");

    // A clean sweep after the aborts
    res_ready = 1'b1;
    load_basic();
    push_exp(0, 8, 0);
    push_exp(1, -11, 0);
    push_exp(2, -18, 0);
    push_exp(3, 0, 0);
    run_start(0, 4, 0, 2, 0, 0);

    // Randomized sweeps against the reference model
    rdy_rand = 1;
    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < 32; i++) begin
        int r, a, b;
        r = $urandom_range(0, 9);
        if (r == 9) r = $urandom_range(9, 15);
        a = $urandom_range(0, 1) ? int'($urandom) : $urandom_range(0, 20) - 10;
        if (r == 8) b = $urandom_range(0, 35) - 2;
        else b = $urandom_range(0, 1) ? int'($urandom) : $urandom_range(0, 8) - 4;
        mem[i] = mk(r, a, b);
      end
      sp  = $urandom_range(0, 31);
      cnt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 32) : $urandom_range(1, 6);
      d   = $urandom_range(0, 1);
      push_model(sp, cnt, d);
      run_start(sp, cnt, d, -1, 0, 1);
    end
    rdy_rand = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_exec_reader.md
INSTR_EXEC_READER -- requirements
Module: instr_exec_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of instruction register locations; pointer arithmetic is modulo DEPTH.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a read sweep; honoured only in IDLE.
REQ-005 SHALL have port start_ptr  input  5  first location of the sweep.
REQ-006 SHALL have port count  input  6  number of locations to read, 1..32; 0 treated as no-op.
REQ-007 SHALL have port dir  input  1  0 = incrementing pointer, 1 = decrementing pointer.
REQ-008 SHALL have port read_pointer  output  5  address driven to the instruction register.
REQ-009 SHALL have port instruction_word  input  instruction_t  {opc 4b, op_a 32b signed, op_b 32b signed, res 64b}, combinational read of read_pointer.
REQ-010 SHALL have port res_valid  output  1  result available.
REQ-011 SHALL have port res_ready  input  1  consumer accepts result.
REQ-012 SHALL have port res_data  output  64  signed computed result.
REQ-013 SHALL have port res_addr  output  5  location the result came from.
REQ-014 SHALL have port res_err  output  1  illegal opcode or unsupported POW exponent for this result.
REQ-015 SHALL have ports busy  output  1 (high outside IDLE) and done  output  1 (one-cycle pulse at sweep end).

Function
REQ-016 SHALL implement FSM IDLE -> FETCH -> EXEC -> OUT -> (FETCH | DONE) -> IDLE.
REQ-017 IDLE: start with count != 0 latches start_ptr/count/dir, drives read_pointer = start_ptr, goes to FETCH; start with count == 0 goes directly to DONE.
REQ-018 FETCH: samples instruction_word into internal opc/op_a/op_b registers at end of cycle; goes to EXEC.
REQ-019 EXEC: ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD complete in 1 cycle; POW iterates one multiply per cycle, op_b cycles, then goes to OUT.
REQ-020 Arithmetic: operands sign-extended to 64 bits; ADD/SUB/MULT signed, full 64-bit result, wrap on overflow.
REQ-021 DIV truncates toward zero; MOD result takes sign of op_a; op_b == 0 gives 0 for both, res_err = 0.
REQ-022 POW: op_a == 0 gives 0; op_b == 0 (op_a != 0) gives 1; op_b < 0 or op_b > 31 gives 0 with res_err = 1 and completes in 1 cycle.
REQ-023 Opcode > 8 (not in opcode_t) SHALL give res_data = 0, res_err = 1.
REQ-024 OUT: res_valid = 1 with res_data/res_addr/res_err stable until the cycle res_valid && res_ready; the data is transferred in that cycle.
REQ-025 On transfer: remaining count decrements; read_pointer advances +1 (dir = 0) or -1 (dir = 1) modulo 32 (31 -> 0, 0 -> 31); goes to FETCH if remaining > 0, else DONE.
REQ-026 DONE: done = 1 for exactly one cycle, busy = 1, then IDLE.
REQ-027 start outside IDLE SHALL be ignored; the sweep in progress is unaffected.
REQ-028 res_ready high outside OUT SHALL have no effect; res_valid never asserts outside OUT.
REQ-029 Best-case throughput is one result per 3 cycles (FETCH, EXEC, OUT with res_ready = 1).
REQ-030 read_pointer SHALL hold its value from FETCH until the transfer in OUT.

Reset
REQ-031 reset_n low at a rising edge SHALL force IDLE regardless of state, including mid-POW and mid-OUT.
REQ-032 Reset values: read_pointer = 0, res_valid = 0, res_data = 0, res_addr = 0, res_err = 0, busy = 0, done = 0; internal counters and registers cleared.
REQ-033 A pending result in OUT SHALL be discarded by reset, with no transfer and no done pulse.

Verification
REQ-034 Locations 0..3 = {ADD 5,3}, {SUB -7,4}, {MULT -3,6}, {DIV 9,0}; start_ptr = 0, count = 4, dir = 0, res_ready = 1 -> results 8, -11, -18, 0; res_addr 0..3; done pulses 1 cycle after last transfer.
REQ-035 start_ptr = 1, count = 3, dir = 1 -> res_addr sequence 1, 0, 31 (wrap).
REQ-036 Location 5 = {POW 2,10} -> res_data = 1024, res_valid 10 EXEC cycles after FETCH; {POW 0,0} -> 0; {POW 3,-1} -> 0 with res_err = 1.
REQ-037 res_ready held low 7 cycles in OUT -> res_valid/res_data stable throughout; exactly one transfer; then next FETCH.
REQ-038 reset_n low during POW iteration and during OUT -> next cycle IDLE, all outputs at reset values, no done; a new start then runs normally.
REQ-039 Opcode 12 at a location -> res_data = 0, res_err = 1; {MOD -7,2} -> -1; start asserted while busy -> ignored.
